// File: rtl/morse_pkg.sv
// Shared Morse constants, state encoding and symbol helper for the Morse
// transmitter and any reader that reuses the code table.
package morse_pkg;

    localparam logic [1:0] SYM_DOT  = 2'b10;
    localparam logic [1:0] SYM_DASH = 2'b11;
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam int         CODE_W   = 10;

    localparam logic [2:0] DOT_U  = 3'd1;
    localparam logic [2:0] DASH_U = 3'd3;
    localparam logic [2:0] GAP_U  = 3'd1;
    localparam logic [2:0] LGAP_U = 3'd3;
    localparam logic [2:0] WGAP_U = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_GAP  = 3'd2,
        ST_LGAP = 3'd3,
        ST_WGAP = 3'd4
    } state_e;

    // Symbol idx counts from the most significant pair; out-of-range reads as none.
    function automatic logic [1:0] sym_at(input logic [CODE_W-1:0] code, input logic [2:0] idx);
        logic [1:0] s;
        case (idx)
            3'd0:    s = code[9:8];
            3'd1:    s = code[7:6];
            3'd2:    s = code[5:4];
            3'd3:    s = code[3:2];
            3'd4:    s = code[1:0];
            default: s = SYM_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/morse_code_rom.sv
// ASCII to Morse code table: {supported, is_space, code}. Lowercase folds to
// uppercase; letters are left-aligned, digits use all five pairs.
module morse_code_rom
    import morse_pkg::*;
(
    input  logic [7:0]        char_i,
    output logic              supported_o,
    output logic              is_space_o,
    output logic [CODE_W-1:0] code_o
);

    logic [7:0] upper_s;

    // Fold lowercase and look the character up.
    always_comb begin
        upper_s     = char_i;
        supported_o = 1'b1;
        is_space_o  = 1'b0;
        code_o      = 10'b00_00_00_00_00;
        if (char_i >= 8'h61 && char_i <= 8'h7A) begin
            upper_s = char_i - 8'd32;
        end else begin
            upper_s = char_i;
        end
        case (upper_s)
            8'h20: is_space_o = 1'b1;
            8'h41: code_o = 10'b10_11_00_00_00;
            8'h42: code_o = 10'b11_10_10_10_00;
            8'h43: code_o = 10'b11_10_11_10_00;
            8'h44: code_o = 10'b11_10_10_00_00;
            8'h45: code_o = 10'b10_00_00_00_00;
            8'h46: code_o = 10'b10_10_11_10_00;
            8'h47: code_o = 10'b11_11_10_00_00;
            8'h48: code_o = 10'b10_10_10_10_00;
            8'h49: code_o = 10'b10_10_00_00_00;
            8'h4A: code_o = 10'b10_11_11_11_00;
            8'h4B: code_o = 10'b11_10_11_00_00;
            8'h4C: code_o = 10'b10_11_10_10_00;
            8'h4D: code_o = 10'b11_11_00_00_00;
            8'h4E: code_o = 10'b11_10_00_00_00;
            8'h4F: code_o = 10'b11_11_11_00_00;
            8'h50: code_o = 10'b10_11_11_10_00;
            8'h51: code_o = 10'b11_11_10_11_00;
            8'h52: code_o = 10'b10_11_10_00_00;
            8'h53: code_o = 10'b10_10_10_00_00;
            8'h54: code_o = 10'b11_00_00_00_00;
            8'h55: code_o = 10'b10_10_11_00_00;
            8'h56: code_o = 10'b10_10_10_11_00;
            8'h57: code_o = 10'b10_11_11_00_00;
            8'h58: code_o = 10'b11_10_10_11_00;
            8'h59: code_o = 10'b11_10_11_11_00;
            8'h5A: code_o = 10'b11_11_10_10_00;
            8'h30: code_o = 10'b11_11_11_11_11;
            8'h31: code_o = 10'b10_11_11_11_11;
            8'h32: code_o = 10'b10_10_11_11_11;
            8'h33: code_o = 10'b10_10_10_11_11;
            8'h34: code_o = 10'b10_10_10_10_11;
            8'h35: code_o = 10'b10_10_10_10_10;
            8'h36: code_o = 10'b11_10_10_10_10;
            8'h37: code_o = 10'b11_11_10_10_10;
            8'h38: code_o = 10'b11_11_11_10_10;
            8'h39: code_o = 10'b11_11_11_11_10;
            default: supported_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts one ASCII character per handshake and keys it out
// as timed marks and gaps, mirroring the active code on code_out.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_TICKS = 5_000_000,
    parameter int unsigned CNT_W      = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_char,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              key_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CODE_W-1:0] code_out
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(UNIT_TICKS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [2:0]         unit_q, unit_d;
    logic [2:0]         sym_q, sym_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               key_q, key_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rdy_q, rdy_d;

    logic               rom_supported_s, rom_space_s;
    logic [CODE_W-1:0]  rom_code_s;
    logic               accept_s, tick_last_s, phase_end_s, restart_s;
    logic [2:0]         phase_units_s;
    logic [1:0]         cur_sym_s, nxt_sym_s;

    morse_code_rom u_rom (
        .char_i      (in_char),
        .supported_o (rom_supported_s),
        .is_space_o  (rom_space_s),
        .code_o      (rom_code_s)
    );

    assign accept_s    = in_valid && rdy_q;
    assign tick_last_s = (tick_q == TICK_LAST);
    assign cur_sym_s   = sym_at(code_q, sym_q);
    assign nxt_sym_s   = sym_at(code_q, sym_q + 3'd1);
    assign phase_end_s = tick_last_s && (unit_q == phase_units_s - 3'd1);

    // Length in units of the phase the current state is timing.
    always_comb begin
        phase_units_s = 3'd1;
        case (state_q)
            ST_MARK: phase_units_s = (cur_sym_s == SYM_DASH) ? DASH_U : DOT_U;
            ST_GAP:  phase_units_s = GAP_U;
            ST_LGAP: phase_units_s = LGAP_U;
            ST_WGAP: phase_units_s = WGAP_U;
            default: phase_units_s = 3'd1;
        endcase
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        sym_d     = sym_q;
        code_d    = code_q;
        err_d     = 1'b0;
        restart_s = 1'b0;
        tick_d    = tick_q;
        unit_d    = unit_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    restart_s = 1'b1;
                    if (!rom_supported_s) begin
                        err_d = 1'b1;
                    end else if (rom_space_s) begin
                        state_d = ST_WGAP;
                    end else begin
                        state_d = ST_MARK;
                        code_d  = rom_code_s;
                        sym_d   = 3'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (phase_end_s) begin
                    restart_s = 1'b1;
                    if (sym_q < 3'd4 && nxt_sym_s != SYM_NONE) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_LGAP;
                    end
                end else begin
                    state_d = ST_MARK;
                end
            end
            ST_GAP: begin
                if (phase_end_s) begin
                    restart_s = 1'b1;
                    sym_d     = sym_q + 3'd1;
                    state_d   = ST_MARK;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_LGAP, ST_WGAP: begin
                if (phase_end_s) begin
                    restart_s = 1'b1;
                    code_d    = 10'd0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                restart_s = 1'b1;
                code_d    = 10'd0;
                state_d   = ST_IDLE;
            end
        endcase

        if (restart_s || state_q == ST_IDLE) begin
            tick_d = '0;
            unit_d = 3'd0;
        end else if (tick_last_s) begin
            tick_d = '0;
            unit_d = unit_q + 3'd1;
        end else begin
            tick_d = tick_q + CNT_W'(1);
            unit_d = unit_q;
        end

        // Outputs are registered, so they are derived from the next-cycle state.
        key_d  = (state_d == ST_MARK);
        busy_d = (state_d != ST_IDLE);
        rdy_d  = (state_d == ST_IDLE) && !err_d;
        done_d = (tick_d == TICK_LAST) &&
                 ((state_d == ST_LGAP && unit_d == LGAP_U - 3'd1) ||
                  (state_d == ST_WGAP && unit_d == WGAP_U - 3'd1));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            unit_q  <= 3'd0;
            sym_q   <= 3'd0;
            code_q  <= 10'd0;
            key_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            unit_q  <= unit_d;
            sym_q   <= sym_d;
            code_q  <= code_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready = rdy_q;
    assign key_out  = key_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign code_out = code_q;

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx: a dot/dash string model builds the expected
// per-cycle waveform, and a negedge process compares the DUT against it.
module tb_morse_tx;

    localparam int U = 4;

    typedef struct packed {
        logic       key;
        logic       busy;
        logic       done;
        logic       err;
        logic       rdy;
        logic [9:0] code;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] code_out;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    exp_t tmp_q[$];

    string LETTERS[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    morse_tx #(.UNIT_TICKS(U), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_char  (in_char),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .key_out  (key_out),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .code_out (code_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic k, input logic b, input logic d,
                                input logic e, input logic r, input logic [9:0] c);
        exp_t x;
        x.key = k; x.busy = b; x.done = d; x.err = e; x.rdy = r; x.code = c;
        return x;
    endfunction

    // Digits: n dots then dashes for 0..5, (n-5) dashes then dots for 6..9.
    function automatic string digit_pat(input int d);
        string s = "";
        for (int k = 0; k < 5; k++) begin
            if (d <= 5) s = {s, (k < d) ? "." : "-"};
            else        s = {s, (k < d - 5) ? "-" : "."};
        end
        return s;
    endfunction

    // Build the expected waveform (cycles 1..L plus the following idle cycle).
    task automatic build(input logic [7:0] c);
        logic [7:0] u;
        string      p;
        bit         ok;
        logic [9:0] code;
        exp_t       e;
        int         off;
        tmp_q.delete();
        u    = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
        ok   = 1'b1;
        p    = "";
        code = 10'd0;
        if (u >= 8'h41 && u <= 8'h5A)      p = LETTERS[u - 8'h41];
        else if (u >= 8'h30 && u <= 8'h39) p = digit_pat(int'(u - 8'h30));
        else if (u != 8'h20)               ok = 1'b0;
        if (!ok) begin
            tmp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0));
        end else begin
            for (int i = 0; i < p.len(); i++)
                code[9 - 2*i -: 2] = (p[i] == ".") ? 2'b10 : 2'b11;
            for (int i = 0; i < p.len(); i++) begin
                repeat ((p[i] == ".") ? U : 3*U) tmp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, code));
                if (i < p.len() - 1) repeat (U) tmp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, code));
            end
            off = (p.len() == 0) ? 7*U : 3*U;
            repeat (off) tmp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, code));
            e = tmp_q.pop_back();
            e.done = 1'b1;
            tmp_q.push_back(e);
        end
        tmp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0));
    endtask

    // Compare every cycle for which the model has an expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("key_out",  {31'd0, key_out},  {31'd0, e.key});
            chk("busy",     {31'd0, busy},     {31'd0, e.busy});
            chk("done",     {31'd0, done},     {31'd0, e.done});
            chk("err",      {31'd0, err},      {31'd0, e.err});
            chk("in_ready", {31'd0, in_ready}, {31'd0, e.rdy});
            chk("code_out", {22'd0, code_out}, {22'd0, e.code});
        end
        cyc++;
    end

    task automatic send(input logic [7:0] c, input bit hold);
        int len;
        @(negedge clk);
        in_char  = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) in_char = 8'h23;
        else      in_valid = 1'b0;
        build(c);
        len = tmp_q.size() - 1;
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        repeat (len) @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;

        // Pin the model against hand-computed figures.
        build(8'h45); chk("model_len_E", tmp_q.size() - 1, 16); chk("model_done_E", {31'd0, tmp_q[15].done}, 1);
        build(8'h41); chk("model_len_A", tmp_q.size() - 1, 32);
        chk("model_A_c8", {31'd0, tmp_q[7].key}, 0); chk("model_A_c9", {31'd0, tmp_q[8].key}, 1);
        build(8'h20); chk("model_len_sp", tmp_q.size() - 1, 28);
        build(8'h39); chk("model_len_9", tmp_q.size() - 1, 80);
        build(8'h54); chk("model_len_T", tmp_q.size() - 1, 24);
        build(8'h58); chk("model_code_X", {22'd0, tmp_q[0].code}, {22'd0, 10'b1110101100});

        repeat (2) @(negedge clk);
        chk("rst_key",   {31'd0, key_out},  0);
        chk("rst_busy",  {31'd0, busy},     0);
        chk("rst_done",  {31'd0, done},     0);
        chk("rst_err",   {31'd0, err},      0);
        chk("rst_ready", {31'd0, in_ready}, 1);
        chk("rst_code",  {22'd0, code_out}, 0);
        rst_n = 1'b1;

        send(8'h45, 1'b0);
        send(8'h41, 1'b0);
        send(8'h61, 1'b1);
        send(8'h20, 1'b0);
        send(8'h23, 1'b0);
        send(8'h39, 1'b0);
        send(8'h45, 1'b0);

        // Abort a 'T' mid-dash with an asynchronous reset.
        @(negedge clk);
        in_char  = 8'h54;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("T_mid_key",  {31'd0, key_out},  1);
        chk("T_mid_code", {22'd0, code_out}, {22'd0, 10'b1100000000});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_key",   {31'd0, key_out},  0);
        chk("abort_ready", {31'd0, in_ready}, 1);
        chk("abort_code",  {22'd0, code_out}, 0);
        chk("abort_busy",  {31'd0, busy},     0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h54, 1'b0);

        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
- Morse transmitter. The inverse of the button-driven Morse reader.
- Accepts one ASCII character per valid/ready handshake and converts it to the team's 10-bit Morse code.
- Plays the code as a timed on/off key signal that drives an LED or buzzer.
- Sits between the message buffer (base/decoded word) and the board output pins; mirrors the current code on the status LEDs.

Parameters:
- UNIT_TICKS, 5_000_000: clk cycles per Morse unit (100 ms at 50 MHz); must be >= 2.
- CNT_W, 23: width of the unit tick counter; must hold UNIT_TICKS-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_char  in  8  ASCII character to send
- in_valid  in  1  in_char is valid
- in_ready  out  1  block can accept a character
- key_out  out  1  Morse key: 1 = mark (tone/LED on)
- busy  out  1  character in progress
- done  out  1  one-cycle pulse on the final gap cycle of a character
- err  out  1  one-cycle pulse: unsupported character dropped
- code_out  out  10  code of the character in progress; 0 when idle

Behaviour:
- Reset (async, rst_n=0): state IDLE; key_out=0, busy=0, done=0, err=0, code_out=0, in_ready=1. Counters are cleared. Reset mid-character aborts immediately, and key_out drops asynchronously.
- Code format: 5 two-bit symbols, MSB pair first. 2'b10 = dot, 2'b11 = dash, 2'b00 = none/terminator.
  - Letters are left-aligned (E = 10_00_00_00_00). Digits use all 5 pairs.
  - X = 11_10_10_11_00. Space = 00_00_00_00_00.
  - Lowercase a-z maps to uppercase. Any other character is unsupported.
- Accept: a transfer occurs on the edge where in_valid && in_ready. in_ready is 0 from the next cycle until the character completes.
- Timing: dot = 1 unit mark; dash = 3 units mark; intra-letter gap = 1 unit off; letter gap after the last mark = 3 units off; space = 7 units off with no mark.
- FSM states: IDLE, MARK, GAP, LGAP, WGAP.
  - IDLE: on accept, look up the code.
    - Supported non-space: code_out=code, sym_idx=0, go to MARK. key_out=1 from the cycle after accept (latency 1).
    - Space: go to WGAP.
    - Unsupported: err=1 in the cycle after accept, stay IDLE; in_ready returns to 1 one cycle after err.
  - MARK: key_out=1 for 1 or 3 units, then:
    - go to GAP if sym_idx<4 and the next pair != 00;
    - otherwise go to LGAP.
  - GAP: 1 unit off, sym_idx++, back to MARK.
  - LGAP: 3 units off. WGAP: 7 units off.
  - Leaving LGAP or WGAP: done=1 on the last cycle, then IDLE with in_ready=1 on the following cycle.
- The unit counter counts 0..UNIT_TICKS-1 and wraps; a unit-count counter tracks units within the state. Phases are exact: N units = N*UNIT_TICKS cycles.
- in_valid held high while not ready is ignored, with no side effects. in_char is only sampled at accept.
- busy = (state != IDLE). code_out is cleared on return to IDLE.

Decomposition:
- morse_pkg holds:
  - localparams SYM_DOT=2'b10, SYM_DASH=2'b11, SYM_NONE=2'b00, CODE_W=10;
  - unit-length constants DOT_U=1, DASH_U=3, GAP_U=1, LGAP_U=3, WGAP_U=7;
  - the state encoding.
- One combinational sub-module, morse_code_rom. It maps ASCII to {supported, is_space, code[9:0]}; the same table is reusable by the reader for decode cross-checks.

Test Plan (UNIT_TICKS=4):
- Send 'E' accepted at cycle 0 -> key_out=1 cycles 1-4, 0 cycles 5-16, done@16, in_ready=1@17, code_out=10'b1000000000 while busy.
- Send 'A' (or 'a') -> key_out high 1-4, low 5-8, high 9-20, low 21-32; done@32; identical waveforms for 'a' and 'A'.
- Send ' ' -> key_out stays 0 for 28 cycles; done@28; busy high 1-28.
- Send '#' -> err=1@1, key_out never rises, in_ready=1@2, no done pulse.
- Send '9' -> four 12-cycle marks, each followed by a 4-cycle gap, then a 4-cycle mark and a 12-cycle letter gap; done@80; back-to-back 'E' accepted at cycle 81 starts its mark at 82.
- Reset: assert rst_n=0 mid-dash of 'T' -> key_out=0, in_ready=1, code_out=0 immediately; after release, 'T' replays fully: 12-cycle mark, done@24.
